arp_receiver: RTL and testbench

Receive-side ARP front end. Consumes the byte stream from the Ethernet MAC RX path, assembles the 42-byte Ethernet+ARP header into an `ether_arp_frame_t`, and filters for ARP requests addressed to our IP. Each accepted request goes to `arp_sender` through a one-entry holding register with a valid/ack handshake. Per-block counters report accepted requests and requests dropped because the holding register was full.

---
 rtl/arp_receiver_if.sv | 42 ++++
 rtl/arp_receiver.sv | 145 ++++++++++++++
 tb/tb_arp_receiver.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_receiver_if.sv
// ARP frame type plus the MAC RX stream / request handshake bundle used by arp_receiver.
// The package sits here so that it is compiled before the interface that uses its frame type.
package arp_pkg;
    localparam int lp_ARP_FRM_SZ = 42;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [15:0] hw_type;
        logic [15:0] proto_type;
        logic [7:0]  hw_len;
        logic [7:0]  proto_len;
        logic [15:0] opcode;
        logic [47:0] sender_mac;
        logic [31:0] sender_ip;
        logic [47:0] target_mac;
        logic [31:0] target_ip;
    } ether_arp_frame_t;
endpackage

interface arp_receiver_if;
    import arp_pkg::*;

    logic [7:0]       mac_data_i;
    logic             mac_valid_i;
    logic             mac_last_i;
    ether_arp_frame_t arp_req_pkt_o;
    logic             arp_req_pkt_valid_o;
    logic             arp_req_pkt_ack_i;

    // master: MAC + downstream consumer side; slave: the receiver itself
    modport master (
        output mac_data_i, mac_valid_i, mac_last_i, arp_req_pkt_ack_i,
        input  arp_req_pkt_o, arp_req_pkt_valid_o
    );

    modport slave (
        input  mac_data_i, mac_valid_i, mac_last_i, arp_req_pkt_ack_i,
        output arp_req_pkt_o, arp_req_pkt_valid_o
    );
endinterface

// File: rtl/arp_receiver.sv
// Assembles the 42-byte Ethernet+ARP header from the MAC RX stream, filters ARP requests
// for our IP and hands them to the sender through a one-entry valid/ack holding register.
module arp_receiver
    import arp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [47:0]         hw_addr_i,
    input  logic [31:0]         ip_addr_i,
    arp_receiver_if.slave       rx_if,
    output logic [15:0]         rx_arp_cnt_o,
    output logic [15:0]         rx_drop_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [5:0] LP_LAST_IDX = 6'(lp_ARP_FRM_SZ - 1);

    logic [1:0]       state_q, state_d;
    logic [5:0]       rx_byte_cnt_q, rx_byte_cnt_d;
    logic             last_seen_q, last_seen_d;
    ether_arp_frame_t frame_q, frame_d;
    ether_arp_frame_t pkt_q, pkt_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [15:0]      rx_arp_cnt_q, rx_arp_cnt_d;
    logic [15:0]      rx_drop_cnt_q, rx_drop_cnt_d;

    logic byte_en;
    logic byte_last;
    logic filter_pass;

    assign byte_en   = rx_if.mac_valid_i;
    assign byte_last = rx_if.mac_valid_i & rx_if.mac_last_i;

    assign filter_pass = (frame_q.ethertype  == 16'h0806) &&
                         (frame_q.hw_type    == 16'h0001) &&
                         (frame_q.proto_type == 16'h0800) &&
                         (frame_q.hw_len     == 8'd6)     &&
                         (frame_q.proto_len  == 8'd4)     &&
                         (frame_q.opcode     == 16'h0001) &&
                         (frame_q.target_ip  == ip_addr_i) &&
                         ((frame_q.dst_mac == 48'hFFFF_FFFF_FFFF) || (frame_q.dst_mac == hw_addr_i));

    // Bytes arrive strictly in order, so shifting in at the LSB leaves byte 0 at the MSB
    // once all 42 bytes are in; a new frame always overwrites the full width.
    always_comb begin
        state_d       = state_q;
        rx_byte_cnt_d = rx_byte_cnt_q;
        last_seen_d   = last_seen_q;
        frame_d       = frame_q;

        if (byte_en && ((state_q == ST_IDLE) || (state_q == ST_RECV))) begin
            frame_d = ether_arp_frame_t'({frame_q[327:0], rx_if.mac_data_i});
        end

        case (state_q)
            ST_IDLE: begin
                if (byte_en) begin
                    rx_byte_cnt_d = byte_last ? 6'd0 : 6'd1;
                    state_d       = byte_last ? ST_IDLE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (byte_en) begin
                    if (rx_byte_cnt_q == LP_LAST_IDX) begin
                        state_d       = ST_CHECK;
                        last_seen_d   = rx_if.mac_last_i;
                        rx_byte_cnt_d = 6'd0;
                    end else if (rx_if.mac_last_i) begin
                        state_d       = ST_IDLE;
                        rx_byte_cnt_d = 6'd0;
                    end else begin
                        rx_byte_cnt_d = rx_byte_cnt_q + 6'd1;
                    end
                end
            end
            ST_CHECK: begin
                // A last on the padding byte in this cycle also ends the frame.
                state_d     = (last_seen_q || byte_last) ? ST_IDLE : ST_DRAIN;
                last_seen_d = 1'b0;
            end
            ST_DRAIN: begin
                if (byte_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A load on the same edge as an ack wins, so valid stays high with the new frame.
    always_comb begin
        pkt_d         = pkt_q;
        pkt_valid_d   = pkt_valid_q;
        rx_arp_cnt_d  = rx_arp_cnt_q;
        rx_drop_cnt_d = rx_drop_cnt_q;

        if (rx_if.arp_req_pkt_ack_i && pkt_valid_q) begin
            pkt_valid_d = 1'b0;
        end

        if ((state_q == ST_CHECK) && filter_pass) begin
            if (!pkt_valid_q || rx_if.arp_req_pkt_ack_i) begin
                pkt_d        = frame_q;
                pkt_valid_d  = 1'b1;
                rx_arp_cnt_d = rx_arp_cnt_q + 16'd1;
            end else begin
                rx_drop_cnt_d = rx_drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rx_byte_cnt_q <= 6'd0;
            last_seen_q   <= 1'b0;
            frame_q       <= '0;
            pkt_q         <= '0;
            pkt_valid_q   <= 1'b0;
            rx_arp_cnt_q  <= 16'd0;
            rx_drop_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            rx_byte_cnt_q <= rx_byte_cnt_d;
            last_seen_q   <= last_seen_d;
            frame_q       <= frame_d;
            pkt_q         <= pkt_d;
            pkt_valid_q   <= pkt_valid_d;
            rx_arp_cnt_q  <= rx_arp_cnt_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
        end
    end

    assign rx_if.arp_req_pkt_o       = pkt_q;
    assign rx_if.arp_req_pkt_valid_o = pkt_valid_q;
    assign rx_arp_cnt_o              = rx_arp_cnt_q;
    assign rx_drop_cnt_o             = rx_drop_cnt_q;

endmodule

// File: tb/tb_arp_receiver.sv
// Randomized bench for arp_receiver: frames are built as byte arrays and a per-frame
// reference model predicts the holding register and counters from the field rules.
module tb_arp_receiver;
    import arp_pkg::*;

    localparam logic [47:0] HW_ADDR = 48'h0200_00AA_BBCC;
    localparam logic [31:0] IP_ADDR = 32'hC0A8_0001;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] hwAddr = HW_ADDR;
    logic [31:0] ipAddr = IP_ADDR;
    logic [15:0] arpCnt;
    logic [15:0] dropCnt;

    arp_receiver_if bus();

    arp_receiver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hw_addr_i     (hwAddr),
        .ip_addr_i     (ipAddr),
        .rx_if         (bus),
        .rx_arp_cnt_o  (arpCnt),
        .rx_drop_cnt_o (dropCnt)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0]   txBytes [64];
    int           txLen;

    logic         expValid;
    logic [335:0] expPkt;
    logic [15:0]  expArp;
    logic [15:0]  expDrop;
    logic         preValid;
    logic         postValid;
    int           sinceByte41;
    logic         pendingAck;

    task automatic checkOutput(input string tag, input logic [335:0] observed, input logic [335:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic void putField(input int off, input int n, input logic [47:0] value);
        for (int k = 0; k < n; k++) txBytes[off + k] = value[8*(n-1-k) +: 8];
    endfunction

    function automatic logic [47:0] getField(input int off, input int n);
        logic [47:0] acc = '0;
        for (int k = 0; k < n; k++) acc = {acc[39:0], txBytes[off + k]};
        return acc;
    endfunction

    function automatic void buildFrame(input logic [47:0] dst, input logic [15:0] etype,
                                       input logic [15:0] opcode, input logic [31:0] tip, input int len);
        for (int k = 0; k < 64; k++) txBytes[k] = 8'($urandom);
        putField(0, 6, dst);
        putField(6, 6, {16'($urandom), 32'($urandom)});
        putField(12, 2, {32'h0, etype});
        putField(14, 2, 48'h0001);
        putField(16, 2, 48'h0800);
        txBytes[18] = 8'd6;
        txBytes[19] = 8'd4;
        putField(20, 2, {32'h0, opcode});
        putField(38, 4, {16'h0, tip});
        txLen = len;
    endfunction

    function automatic bit refPass();
        logic [47:0] dst = getField(0, 6);
        return (getField(12, 2) == 48'h0806) && (getField(14, 2) == 48'h0001) &&
               (getField(16, 2) == 48'h0800) && (txBytes[18] == 8'd6) && (txBytes[19] == 8'd4) &&
               (getField(20, 2) == 48'h0001) && (getField(38, 4) == {16'h0, ipAddr}) &&
               ((dst == BCAST) || (dst == hwAddr));
    endfunction

    function automatic logic [335:0] refPkt();
        logic [335:0] p = '0;
        for (int i = 0; i < 42; i++) p[335 - 8*i -: 8] = txBytes[i];
        return p;
    endfunction

    // Evaluated once the 42nd byte is on the wire; ack is what the consumer shows in ST_CHECK.
    function automatic void refUpdate(input logic ack);
        preValid = expValid;
        if (refPass()) begin
            if (!expValid || ack) begin
                expPkt   = refPkt();
                expValid = 1'b1;
                expArp   = expArp + 16'd1;
            end else begin
                expDrop = expDrop + 16'd1;
            end
        end else if (ack) begin
            expValid = 1'b0;
        end
        postValid = expValid;
    endfunction

    task automatic driveCycle(input logic v, input logic [7:0] d, input logic l);
        @(negedge clk);
        if (sinceByte41 == 1) checkOutput("valid_during_check", bus.arp_req_pkt_valid_o, preValid);
        else if (sinceByte41 == 2) checkOutput("valid_after_check", bus.arp_req_pkt_valid_o, postValid);
        bus.arp_req_pkt_ack_i = (sinceByte41 == 1) ? pendingAck : 1'b0;
        bus.mac_valid_i = v;
        bus.mac_data_i  = d;
        bus.mac_last_i  = l;
        if (sinceByte41 > 0) sinceByte41 = (sinceByte41 == 2) ? 0 : sinceByte41 + 1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, bus.arp_req_pkt_valid_o, expValid);
        checkOutput({tag, "_pkt"}, bus.arp_req_pkt_o, expPkt);
        checkOutput({tag, "_arp_cnt"}, arpCnt, expArp);
        checkOutput({tag, "_drop_cnt"}, dropCnt, expDrop);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mac_valid_i = 1'b0;
        bus.mac_last_i  = 1'b0;
        bus.arp_req_pkt_ack_i = 1'b0;
        expValid = 1'b0;
        expPkt   = '0;
        expArp   = 16'd0;
        expDrop  = 16'd0;
        sinceByte41 = 0;
        repeat (2) @(negedge clk);
        checkAll(tag);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic ackPulse();
        @(negedge clk);
        bus.arp_req_pkt_ack_i = 1'b1;
        bus.mac_valid_i = 1'b0;
        expValid = 1'b0;
        @(negedge clk);
        bus.arp_req_pkt_ack_i = 1'b0;
    endtask

    // Sends txBytes[0..txLen-1] with random idle gaps; resetAt >= 0 aborts the frame with a reset.
    task automatic applyStimulus(input int gapPct, input logic ackAtCheck, input int resetAt);
        pendingAck = ackAtCheck;
        for (int i = 0; i < txLen; i++) begin
            if (i == resetAt) begin
                doReset("mid_frame_reset");
                return;
            end
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(99) < gapPct) driveCycle(1'b0, 8'($urandom), 1'($urandom));
            end
            driveCycle(1'b1, txBytes[i], i == txLen - 1);
            if (i == 41) begin
                sinceByte41 = 1;
                refUpdate(ackAtCheck);
            end
        end
        repeat (3) driveCycle(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.mac_valid_i = 1'b0;
        bus.mac_data_i  = 8'h00;
        bus.mac_last_i  = 1'b0;
        bus.arp_req_pkt_ack_i = 1'b0;
        sinceByte41 = 0;
        pendingAck  = 1'b0;
        doReset("reset");

        $display("[TB] broadcast request, 60 bytes");
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(0, 1'b0, -1);
        checkAll("bcast");
        ackPulse();
        checkAll("bcast_acked");
        ackPulse();
        checkAll("ack_when_empty");

        $display("[TB] filter rejects and unicast match");
        buildFrame(BCAST, 16'h0806, 16'h0002, IP_ADDR, 60);
        applyStimulus(0, 1'b0, -1);
        checkAll("rej_opcode");
        buildFrame(BCAST, 16'h0800, 16'h0001, IP_ADDR, 60);
        applyStimulus(0, 1'b0, -1);
        checkAll("rej_ethertype");
        buildFrame(BCAST, 16'h0806, 16'h0001, 32'hC0A8_0002, 60);
        applyStimulus(0, 1'b0, -1);
        checkAll("rej_target_ip");
        buildFrame(48'h0200_00AA_BBCD, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(0, 1'b0, -1);
        checkAll("rej_unicast");
        buildFrame(HW_ADDR, 16'h0806, 16'h0001, IP_ADDR, 50);
        applyStimulus(0, 1'b0, -1);
        checkAll("unicast_match");
        ackPulse();

        $display("[TB] runt then exact 42-byte frame");
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 30);
        applyStimulus(0, 1'b0, -1);
        checkAll("runt");
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 42);
        applyStimulus(0, 1'b0, -1);
        checkAll("exact42");
        buildFrame(HW_ADDR, 16'h0806, 16'h0001, IP_ADDR, 42);
        applyStimulus(0, 1'b1, -1);
        checkAll("exact42_followup");
        ackPulse();

        $display("[TB] holding register full");
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(0, 1'b0, -1);
        buildFrame(HW_ADDR, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(0, 1'b0, -1);
        checkAll("full_drop");
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 64);
        applyStimulus(0, 1'b1, -1);
        checkAll("ack_same_cycle_load");
        ackPulse();

        $display("[TB] randomized frames with gaps");
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(5);
            int len  = $urandom_range(64, 42);
            case (kind)
                0: buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, len);
                1: buildFrame(HW_ADDR, 16'h0806, 16'h0001, IP_ADDR, len);
                2: buildFrame({16'($urandom), 32'($urandom)}, 16'h0806, 16'h0001, IP_ADDR, len);
                3: buildFrame(BCAST, 16'h0806, 16'($urandom_range(3)), IP_ADDR, len);
                4: buildFrame(BCAST, 16'h0806, 16'h0001, {IP_ADDR[31:2], 2'($urandom)}, len);
                default: begin
                    buildFrame(HW_ADDR, 16'h0806, 16'h0001, IP_ADDR, len);
                    txBytes[$urandom_range(21, 12)] ^= 8'(1 << $urandom_range(7));
                end
            endcase
            applyStimulus(30, 1'($urandom), -1);
            checkAll("random");
            if ($urandom_range(2) == 0) ackPulse();
        end

        $display("[TB] accepted-request counter wrap");
        ackPulse();
        @(negedge clk);
        force dut.rx_arp_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.rx_arp_cnt_q;
        expArp = 16'hFFFF;
        checkOutput("cnt_preload", arpCnt, expArp);
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(20, 1'b0, -1);
        checkAll("cnt_wrap");

        $display("[TB] reset mid-frame then clean frame");
        buildFrame(HW_ADDR, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(0, 1'b0, 20);
        buildFrame(BCAST, 16'h0806, 16'h0001, IP_ADDR, 60);
        applyStimulus(10, 1'b0, -1);
        checkAll("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
